// File: rtl/fetch_buffer.sv
// Circular FIFO between instruction fetch and decode. Empty slots present a NOP.
// Optional same-cycle bypass when the buffer is empty: define FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
    parameter int unsigned BUFFER_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_instr_i,
    input  logic [31:0] fetch_address_i,
    input  logic        fetch_compressed_i,
    input  logic        fetch_exception_i,
    output logic        fetch_ready_o,
    input  logic        read_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_address_o,
    output logic        compressed_o,
    output logic        exception_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned PtrW = $clog2(BUFFER_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [31:0] Nop  = 32'h0000_0013;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full_q, empty_q;

    logic [31:0] instr_mem [BUFFER_DEPTH];
    logic [31:0] addr_mem  [BUFFER_DEPTH];
    logic        comp_mem  [BUFFER_DEPTH];
    logic        exc_mem   [BUFFER_DEPTH];

    logic push, pop, bypass;

`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass = empty_q & fetch_valid_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign fetch_ready_o = ~full_q;
    // A bypassed entry consumed in the same cycle never enters storage.
    assign push = fetch_valid_i & ~full_q & ~flush_i & ~(bypass & read_i);
    assign pop  = read_i & ~empty_q & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CntW'(BUFFER_DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    // Storage is not reset; the pointers alone define what is live.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            instr_mem[wr_ptr_q] <= fetch_instr_i;
            addr_mem[wr_ptr_q]  <= fetch_address_i;
            comp_mem[wr_ptr_q]  <= fetch_compressed_i;
            exc_mem[wr_ptr_q]   <= fetch_exception_i;
        end
    end

    always_comb begin
        valid_o         = ~empty_q | bypass;
        instr_o         = Nop;
        instr_address_o = '0;
        compressed_o    = 1'b0;
        exception_o     = 1'b0;
        if (!empty_q) begin
            instr_o         = instr_mem[rd_ptr_q];
            instr_address_o = addr_mem[rd_ptr_q];
            compressed_o    = comp_mem[rd_ptr_q];
            exception_o     = exc_mem[rd_ptr_q];
        end else if (bypass) begin
            instr_o         = fetch_instr_i;
            instr_address_o = fetch_address_i;
            compressed_o    = fetch_compressed_i;
            exception_o     = fetch_exception_i;
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: queue-based reference model checked every cycle plus directed
// literal checks. Honours FETCH_BUFFER_BYPASS_EN in the same way as the design.
module tb_fetch_buffer;

    localparam int unsigned Depth = 8;
`ifdef FETCH_BUFFER_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        comp;
        logic        exc;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        fv = 1'b0;
    logic [31:0] fi = '0;
    logic [31:0] fa = '0;
    logic        fc = 1'b0;
    logic        fe = 1'b0;
    logic        rd = 1'b0;
    logic        ready, valid, comp, exc, full, empty;
    logic [31:0] instr, iaddr;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    entry_t model_q[$];

    fetch_buffer #(.BUFFER_DEPTH(Depth)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .flush_i            (flush),
        .fetch_valid_i      (fv),
        .fetch_instr_i      (fi),
        .fetch_address_i    (fa),
        .fetch_compressed_i (fc),
        .fetch_exception_i  (fe),
        .fetch_ready_o      (ready),
        .read_i             (rd),
        .valid_o            (valid),
        .instr_o            (instr),
        .instr_address_o    (iaddr),
        .compressed_o       (comp),
        .exception_o        (exc),
        .full_o             (full),
        .empty_o            (empty)
    );

    always #5 clk = ~clk;

    function automatic entry_t mk(input logic [31:0] a);
        entry_t e;
        e.instr = {a[15:0] ^ 16'hBEEF, a[15:0]};
        e.addr  = a;
        e.comp  = a[2];
        e.exc   = (a[5:2] == 4'd3);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queue updated at each rising edge from the sampled inputs.
    bit m_byp, m_pop, m_push;
    always @(posedge clk) begin
        if (rst || flush) begin
            model_q.delete();
        end else begin
            m_byp  = Byp && model_q.size() == 0 && fv;
            m_pop  = rd && model_q.size() != 0;
            m_push = fv && model_q.size() < Depth && !(m_byp && rd);
            if (m_pop) void'(model_q.pop_front());
            if (m_push) model_q.push_back(mk(fa));
        end
    end

    entry_t c_head;
    bit     c_byp, c_valid;
    always @(negedge clk) begin
        if (chk_en) begin
            c_byp   = Byp && model_q.size() == 0 && fv && !flush;
            c_valid = model_q.size() != 0 || c_byp;
            if (model_q.size() != 0)
                c_head = model_q[0];
            else if (c_byp)
                c_head = '{instr: fi, addr: fa, comp: fc, exc: fe};
            else
                c_head = '{instr: 32'h13, addr: 32'h0, comp: 1'b0, exc: 1'b0};
            check("m_valid", {31'b0, valid}, {31'b0, c_valid});
            check("m_instr", instr, c_head.instr);
            check("m_addr", iaddr, c_head.addr);
            check("m_comp", {31'b0, comp}, {31'b0, c_head.comp});
            check("m_exc", {31'b0, exc}, {31'b0, c_head.exc});
            check("m_full", {31'b0, full}, {31'b0, model_q.size() == Depth});
            check("m_empty", {31'b0, empty}, {31'b0, model_q.size() == 0});
            check("m_ready", {31'b0, ready}, {31'b0, model_q.size() != Depth});
        end
    end

    task automatic drive(input bit v, input logic [31:0] a, input bit r, input bit f,
                         input bit rs);
        entry_t e;
        @(posedge clk);
        #1;
        e     = mk(a);
        fv    = v;
        fa    = a;
        fi    = e.instr;
        fc    = e.comp;
        fe    = e.exc;
        rd    = r;
        flush = f;
        rst   = rs;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    int n;
    int k;

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);

        // Three pushes, no reads.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        check("p3_valid", {31'b0, valid}, 32'd1);
        check("p3_addr", iaddr, 32'h100);
        check("p3_empty", {31'b0, empty}, 32'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        check("p3_drained", {31'b0, empty}, 32'd1);

        // Fill, then push+pop while full: push rejected.
        for (int i = 0; i < 8; i++) drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        check("fill_full", {31'b0, full}, 32'd1);
        drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("full_ready", {31'b0, ready}, 32'd0);
        idle();
        @(negedge clk);
        check("full_after", {31'b0, full}, 32'd0);
        check("full_head", iaddr, 32'h304);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            if (valid) n++;
        end
        check("full_count7", n, 32'd7);

        // Streaming 20 entries through with continuous reads.
        k = 0;
        for (int i = 0; i < 26; i++) begin
            if (i < 20) drive(1'b1, 32'h500 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
            else drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            if (valid) begin
                check("stream_order", iaddr, 32'h500 + 32'(4 * k));
                k++;
            end
        end
        check("stream_count", k, 32'd20);

        // Flush with concurrent push and read.
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h700, 1'b1, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        check("flush_valid", {31'b0, valid}, 32'd0);
        check("flush_instr", instr, 32'h0000_0013);
        check("flush_empty", {31'b0, empty}, 32'd1);

        // Push into empty buffer with read high.
        drive(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("byp_valid0", {31'b0, valid}, {31'b0, Byp});
        if (Byp) check("byp_addr0", iaddr, 32'h200);
        idle();
        @(negedge clk);
        check("byp_valid1", {31'b0, valid}, {31'b0, !Byp});
        check("byp_empty1", {31'b0, empty}, {31'b0, Byp});
        if (!Byp) check("byp_addr1", iaddr, 32'h200);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle();

        // Reset while half full with a push active.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h800 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h900, 1'b0, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        check("rst_mid_empty", {31'b0, empty}, 32'd1);
        check("rst_mid_valid", {31'b0, valid}, 32'd0);
        idle();
        @(negedge clk);
        check("rst_mid_lost", {31'b0, valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter BUFFER_DEPTH, default 8, number of entries; SHALL be a power of two, 2..64.
REQ-002 clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 flush_i  input  1  discard all entries (branch mispredict or trap).
REQ-005 fetch_valid_i  input  1  fetch unit presents an instruction.
REQ-006 fetch_instr_i  input  32  instruction word, already expanded if compressed.
REQ-007 fetch_address_i  input  32  instruction address.
REQ-008 fetch_compressed_i  input  1  instruction was 16-bit.
REQ-009 fetch_exception_i  input  1  instruction access fault on this fetch.
REQ-010 fetch_ready_o  output  1  buffer can accept an entry this cycle.
REQ-011 read_i  input  1  decode consumes the head entry.
REQ-012 valid_o  output  1  head entry valid.
REQ-013 instr_o  output  32  head instruction, to decode instr_i.
REQ-014 instr_address_o  output  32  head address, to decode instr_address_i.
REQ-015 compressed_o  output  1  head compressed flag.
REQ-016 exception_o  output  1  head fetch fault.
REQ-017 full_o, empty_o  output  1 each  occupancy status.

Function
REQ-018 Storage SHALL be a circular FIFO: write pointer, read pointer (log2(BUFFER_DEPTH) bits, wrapping to 0 after BUFFER_DEPTH-1), and count (log2(BUFFER_DEPTH)+1 bits).
REQ-019 Push SHALL occur when fetch_valid_i && fetch_ready_o && !flush_i. fetch_ready_o SHALL be !full_o, combinational.
REQ-020 Pop SHALL occur when read_i && valid_o && !flush_i. read_i with valid_o=0 SHALL be ignored.
REQ-021 Simultaneous push and pop SHALL leave the count unchanged and advance both pointers.
REQ-022 When full, a push SHALL be rejected even if a pop occurs the same cycle.
REQ-023 full_o SHALL equal (count == BUFFER_DEPTH). empty_o SHALL equal (count == 0). Both SHALL be registered state decodes.
REQ-024 Outputs SHALL reflect the head entry combinationally from storage. A pushed entry SHALL appear on the outputs 1 cycle after push.
REQ-025 When valid_o=0, outputs SHALL be: instr_o = 32'h00000013 (NOP), instr_address_o = 0, compressed_o = 0, exception_o = 0.
REQ-026 flush_i SHALL, on the next edge, zero both pointers and the count; the same-cycle push and pop SHALL be discarded.
REQ-027 valid_o SHALL be 0 in the cycle after a flush unless bypass applies (REQ-031).
REQ-028 Entries SHALL be delivered strictly in push order; no entry SHALL be duplicated or dropped except by flush.

Reset
REQ-029 While rst_i is high at an edge: pointers = 0, count = 0, so valid_o = 0, full_o = 0, empty_o = 1, and data outputs per REQ-025.
REQ-030 Reset SHALL take priority over flush_i, push, and pop. Storage contents need not be cleared.

Configuration
REQ-031 Macro FETCH_BUFFER_BYPASS_EN.
- Defined: when empty and fetch_valid_i && !flush_i, the fetch inputs SHALL drive the outputs directly with valid_o = 1 in the same cycle. If read_i is also high, the entry SHALL NOT be written and the count stays 0. Otherwise it is written normally.
- Undefined: no bypass path; latency is always per REQ-024.

Verification
REQ-032 Reset, then push 3 entries (addr 0x100, 0x104, 0x108) with read_i = 0 -> count 3, valid_o = 1, instr_address_o = 0x100, empty_o = 0.
REQ-033 Fill all 8 entries, then hold fetch_valid_i and read_i high for 1 cycle -> one pop; push rejected; fetch_ready_o = 0 during that cycle; count becomes 7.
REQ-034 Push 20 sequential entries while popping continuously with depth 8 -> outputs in order with pointers wrapping; no loss; count stays at most 8.
REQ-035 With 5 entries stored, assert flush_i together with push and read -> next cycle count 0, valid_o = 0, instr_o = 0x00000013.
REQ-036 Empty buffer, push addr 0x200 with read_i = 1 -> with FETCH_BUFFER_BYPASS_EN: same-cycle valid_o = 1, address 0x200, count stays 0. Without it: valid_o = 0 that cycle, then 1 next cycle.
REQ-037 Assert rst_i while the buffer is half full and a push is active -> next cycle empty_o = 1, valid_o = 0, pushed entry lost.
